// File: rtl/exception_unit.sv
// Exception/interrupt unit for the multi-cycle datapath: holds EPC, Cause and Status,
// synchronises external interrupt lines and runs the IDLE/HANDLER entry-return FSM.
module exception_unit #(
  parameter int unsigned          WIDTH       = 16,
  parameter int unsigned          NIRQ        = 4,
  parameter logic [WIDTH-1:0]     VECTOR_BASE = 16'hFF00
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [WIDTH-1:0] PC,
  input  logic             EPCWrite,
  input  logic             CauseWrite,
  input  logic             IntCause,
  input  logic             ERet,
  input  logic             StatusWrite,
  input  logic [NIRQ:0]    StatusIn,
  input  logic [NIRQ-1:0]  irq,
  output logic             IntReq,
  output logic [WIDTH-1:0] EPC,
  output logic [3:0]       Cause,
  output logic [WIDTH-1:0] HandlerAddr,
  output logic [WIDTH-1:0] ReturnPC,
  output logic [NIRQ:0]    Status,
  output logic             InHandler,
  output logic             DoubleFault
);

  typedef enum logic {
    IDLE    = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam logic [3:0] CAUSE_SYSCALL  = 4'd0;
  localparam logic [3:0] CAUSE_SPURIOUS = 4'd15;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  epc_q, epc_d;
  logic [3:0]        cause_q, cause_d;
  logic              ie_q, ie_d;
  logic              previe_q, previe_d;
  logic [NIRQ-1:0]   mask_q, mask_d;
  logic [NIRQ-1:0]   pend_q, pend_d;
  logic              df_q, df_d;
  logic [NIRQ-1:0]   sync1_q, sync2_q, prev_q;

  logic [NIRQ-1:0]   edge_det;
  logic [NIRQ-1:0]   masked;
  logic [NIRQ-1:0]   sel_onehot;
  logic [3:0]        sel_idx;
  logic              sel_valid;

  assign edge_det = sync2_q & ~prev_q;
  assign masked   = pend_q & mask_q;

  // Lowest-index masked pending line wins.
  always_comb begin
    sel_valid  = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NIRQ; i++) begin
      if (!sel_valid && masked[i]) begin
        sel_valid     = 1'b1;
        sel_idx       = 4'(i);
        sel_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [NIRQ-1:0] clr;
    state_d  = state_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    ie_d     = ie_q;
    previe_d = previe_q;
    mask_d   = mask_q;
    df_d     = df_q;
    clr      = '0;

    if (EPCWrite)
      epc_d = PC;

    if (StatusWrite) begin
      mask_d = StatusIn[NIRQ:1];
      ie_d   = StatusIn[0];
    end

    // CauseWrite overrides StatusIn IE; ERet yields to StatusIn IE.
    if (CauseWrite) begin
      if (state_q == IDLE) begin
        if (!IntCause) begin
          cause_d = CAUSE_SYSCALL;
        end else if (sel_valid) begin
          cause_d = sel_idx + 4'd1;
          clr     = sel_onehot;
        end else begin
          cause_d = CAUSE_SPURIOUS;
        end
        previe_d = ie_q;
        ie_d     = 1'b0;
        state_d  = HANDLER;
      end else begin
        cause_d = CAUSE_SPURIOUS;
        df_d    = 1'b1;
      end
    end else if (ERet && state_q == HANDLER) begin
      if (!StatusWrite)
        ie_d = previe_q;
      state_d = IDLE;
    end

    pend_d = (pend_q & ~clr) | edge_det;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      ie_q     <= 1'b0;
      previe_q <= 1'b0;
      mask_q   <= '0;
      pend_q   <= '0;
      df_q     <= 1'b0;
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      ie_q     <= ie_d;
      previe_q <= previe_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      df_q     <= df_d;
      sync1_q  <= irq;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
    end
  end

  assign IntReq      = ie_q && (state_q == IDLE) && (|masked);
  assign EPC         = epc_q;
  assign ReturnPC    = epc_q;
  assign Cause       = cause_q;
  assign HandlerAddr = VECTOR_BASE + WIDTH'({cause_q, 2'b00});
  assign Status      = {mask_q, ie_q};
  assign InHandler   = (state_q == HANDLER);
  assign DoubleFault = df_q;

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios with literal expectations, then random
// stimulus compared every cycle against a rule-level model of the unit.
module tb_exception_unit;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIRQ  = 4;

  logic             CLK = 1'b0;
  logic             Reset;
  logic [WIDTH-1:0] PC;
  logic             EPCWrite, CauseWrite, IntCause, ERet, StatusWrite;
  logic [NIRQ:0]    StatusIn;
  logic [NIRQ-1:0]  irq;
  logic             IntReq, InHandler, DoubleFault;
  logic [WIDTH-1:0] EPC, HandlerAddr, ReturnPC;
  logic [3:0]       Cause;
  logic [NIRQ:0]    Status;

  exception_unit #(.WIDTH(WIDTH), .NIRQ(NIRQ), .VECTOR_BASE(16'hFF00)) dut (
    .CLK(CLK), .Reset(Reset), .PC(PC), .EPCWrite(EPCWrite), .CauseWrite(CauseWrite),
    .IntCause(IntCause), .ERet(ERet), .StatusWrite(StatusWrite), .StatusIn(StatusIn),
    .irq(irq), .IntReq(IntReq), .EPC(EPC), .Cause(Cause), .HandlerAddr(HandlerAddr),
    .ReturnPC(ReturnPC), .Status(Status), .InHandler(InHandler), .DoubleFault(DoubleFault)
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus the last three sampled irq words.
  logic [WIDTH-1:0] m_epc = '0;
  logic [3:0]       m_cause = '0;
  logic             m_ie = 1'b0, m_previe = 1'b0, m_inh = 1'b0, m_df = 1'b0;
  logic [NIRQ-1:0]  m_mask = '0, m_pend = '0;
  logic [NIRQ-1:0]  h1 = '0, h2 = '0, h3 = '0;

  initial begin
    logic [NIRQ-1:0] rise, avail, clr;
    int sel;
    logic old_ie;
    forever begin
      @(posedge CLK or posedge Reset);
      if (Reset) begin
        m_epc = '0; m_cause = '0; m_ie = 0; m_previe = 0; m_inh = 0; m_df = 0;
        m_mask = '0; m_pend = '0; h1 = '0; h2 = '0; h3 = '0;
      end else begin
        // A rise seen between samples n-3 and n-2 becomes pending at sample n.
        rise  = h2 & ~h3;
        avail = m_pend & m_mask;
        sel   = -1;
        for (int i = NIRQ - 1; i >= 0; i--)
          if (avail[i]) sel = i;
        old_ie = m_ie;
        clr    = '0;
        if (StatusWrite) begin
          m_mask = StatusIn[NIRQ:1];
          m_ie   = StatusIn[0];
        end
        if (CauseWrite) begin
          if (!m_inh) begin
            if (!IntCause) m_cause = 4'd0;
            else if (sel >= 0) begin
              m_cause = 4'(sel + 1);
              clr[sel] = 1'b1;
            end else m_cause = 4'd15;
            m_previe = old_ie;
            m_ie     = 1'b0;
            m_inh    = 1'b1;
          end else begin
            m_cause = 4'd15;
            m_df    = 1'b1;
          end
        end else if (ERet && m_inh) begin
          if (!StatusWrite) m_ie = m_previe;
          m_inh = 1'b0;
        end
        if (EPCWrite) m_epc = PC;
        m_pend = (m_pend & ~clr) | rise;
        h3 = h2; h2 = h1; h1 = irq;
      end
    end
  end

  bit cmp_en = 1'b0;

  initial begin
    forever begin
      @(negedge CLK);
      if (cmp_en) begin
        chk("IntReq",      32'(IntReq),      32'(m_ie && !m_inh && (|(m_pend & m_mask))));
        chk("EPC",         32'(EPC),         32'(m_epc));
        chk("ReturnPC",    32'(ReturnPC),    32'(m_epc));
        chk("Cause",       32'(Cause),       32'(m_cause));
        chk("HandlerAddr", 32'(HandlerAddr), (32'hFF00 + 32'(m_cause) * 4) & 32'hFFFF);
        chk("Status",      32'(Status),      32'({m_mask, m_ie}));
        chk("InHandler",   32'(InHandler),   32'(m_inh));
        chk("DoubleFault", 32'(DoubleFault), 32'(m_df));
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  task automatic status_wr(input logic [NIRQ:0] v);
    StatusIn = v; StatusWrite = 1'b1;
    step();
    StatusWrite = 1'b0;
  endtask

  task automatic cause_wr(input logic ic);
    IntCause = ic; CauseWrite = 1'b1;
    step();
    CauseWrite = 1'b0;
  endtask

  task automatic eret();
    ERet = 1'b1;
    step();
    ERet = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; PC = '0; EPCWrite = 0; CauseWrite = 0; IntCause = 0; ERet = 0;
    StatusWrite = 0; StatusIn = '0; irq = '0;
    cmp_en = 1'b1;
    step(); step();
    Reset = 1'b0;

    // Reset state, then requests latch even with IE=0
    chk("rst_EPC", 32'(EPC), 32'h0);
    chk("rst_Cause", 32'(Cause), 32'h0);
    chk("rst_Status", 32'(Status), 32'h0);
    chk("rst_IntReq", 32'(IntReq), 32'h0);
    chk("rst_InHandler", 32'(InHandler), 32'h0);
    chk("rst_DoubleFault", 32'(DoubleFault), 32'h0);
    chk("rst_HandlerAddr", 32'(HandlerAddr), 32'hFF00);
    irq = 4'hF;
    repeat (4) step();
    chk("ie0_IntReq", 32'(IntReq), 32'h0);
    status_wr(5'h1F);
    chk("ie1_Status", 32'(Status), 32'h1F);
    chk("ie1_IntReq", 32'(IntReq), 32'h1);
    cause_wr(1'b1);
    chk("allpend_Cause", 32'(Cause), 32'h1);
    chk("allpend_HA", 32'(HandlerAddr), 32'hFF04);
    eret();
    chk("allpend_left", 32'(IntReq), 32'h1);
    irq = '0;
    do_reset();

    // Priority and edge-to-request latency
    status_wr(5'h1F);
    irq = 4'b0110;
    step(); step();
    chk("lat_early", 32'(IntReq), 32'h0);
    step();
    chk("lat_3cyc", 32'(IntReq), 32'h1);
    cause_wr(1'b1);
    chk("prio_Cause", 32'(Cause), 32'h2);
    chk("prio_HA", 32'(HandlerAddr), 32'hFF08);
    eret();
    chk("prio_left", 32'(IntReq), 32'h1);
    cause_wr(1'b1);
    chk("prio_second", 32'(Cause), 32'h3);
    eret();
    chk("prio_empty", 32'(IntReq), 32'h0);

    // Syscall entry and return
    PC = 16'h0042; EPCWrite = 1'b1;
    cause_wr(1'b0);
    EPCWrite = 1'b0; PC = 16'h1234;
    chk("sys_EPC", 32'(EPC), 32'h42);
    chk("sys_Cause", 32'(Cause), 32'h0);
    chk("sys_InHandler", 32'(InHandler), 32'h1);
    chk("sys_Status", 32'(Status), 32'h1E);
    eret();
    chk("sys_ret_Status", 32'(Status), 32'h1F);
    chk("sys_ReturnPC", 32'(ReturnPC), 32'h42);
    chk("sys_ret_InHandler", 32'(InHandler), 32'h0);

    // Nested exception -> sticky double fault
    cause_wr(1'b0);
    cause_wr(1'b0);
    chk("nest_Cause", 32'(Cause), 32'hF);
    chk("nest_DF", 32'(DoubleFault), 32'h1);
    eret();
    chk("nest_DF_eret", 32'(DoubleFault), 32'h1);
    chk("nest_IE", 32'(Status), 32'h1F);
    do_reset();
    chk("nest_DF_reset", 32'(DoubleFault), 32'h0);

    // Masking and spurious interrupt
    status_wr(5'h1F);
    irq = 4'b0100;
    repeat (3) step();
    status_wr(5'h03);
    chk("mask_IntReq", 32'(IntReq), 32'h0);
    cause_wr(1'b1);
    chk("spur_Cause", 32'(Cause), 32'hF);
    chk("spur_HA", 32'(HandlerAddr), 32'hFF3C);
    eret();
    status_wr(5'h1F);
    chk("spur_kept", 32'(IntReq), 32'h1);
    irq = '0;
    do_reset();

    // New edge landing on the cycle its line is cleared; reset mid-handler
    status_wr(5'h03);
    irq = 4'b0001;
    step();
    irq = 4'b0000;
    step();
    irq = 4'b0001;
    step();
    chk("race_req", 32'(IntReq), 32'h1);
    step();
    cause_wr(1'b1);
    chk("race_Cause", 32'(Cause), 32'h1);
    eret();
    chk("race_setwins", 32'(IntReq), 32'h1);
    cause_wr(1'b1);
    chk("race_Cause2", 32'(Cause), 32'h1);
    irq = '0;
    do_reset();
    chk("midrst_InHandler", 32'(InHandler), 32'h0);
    chk("midrst_Status", 32'(Status), 32'h0);
    status_wr(5'h1F);
    chk("midrst_pend", 32'(IntReq), 32'h0);

    // Random phase
    for (int c = 0; c < 4000; c++) begin
      Reset       = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 5) == 0) irq = irq ^ 4'($urandom);
      PC          = 16'($urandom);
      EPCWrite    = ($urandom_range(0, 3) == 0);
      CauseWrite  = ($urandom_range(0, 5) == 0);
      IntCause    = ($urandom_range(0, 3) != 0);
      ERet        = ($urandom_range(0, 4) == 0);
      StatusWrite = ($urandom_range(0, 9) == 0);
      StatusIn    = {4'($urandom), ($urandom_range(0, 3) != 0)};
      step();
    end
    Reset = 0; EPCWrite = 0; CauseWrite = 0; ERet = 0; StatusWrite = 0;
    step();
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
